// File: rtl/universal_shift_register_if.sv
// Request/response bundle for universal_shift_register: operation request in,
// register contents and status out.
interface universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] data;
  logic             ser_in;
  logic [WIDTH-1:0] y;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, data, ser_in,
    input  y, ser_out, busy, done
  );

  modport slave (
    input  start, op, amt, data, ser_in,
    output y, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: load/clear/hold plus logical, arithmetic
// and rotate shifts, multi-position shifts executed one position per clock.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops and the first shift apply here
// SHIFT | multi-position shift in progress, cnt_q shifts still to go
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  universal_shift_register_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [AMT_W-1:0] amt_n;
  logic [2:0]       shift_op;
  logic [WIDTH:0]   shifted;

  // Returns {bit shifted out, new register value} for one position.
  function automatic logic [WIDTH:0] shift_one(input logic [2:0] op,
                                               input logic [WIDTH-1:0] v,
                                               input logic sin);
    logic [WIDTH:0] r;
    r = {1'b0, v};
    case (op)
      OP_SHR:  r = {v[0], sin, v[WIDTH-1:1]};
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], sin};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  assign amt_n    = (bus.amt > AMT_MAX) ? AMT_MAX : bus.amt;
  assign shift_op = (state_q == SHIFT) ? op_q : bus.op;
  assign shifted  = shift_one(shift_op, y_q, bus.ser_in);

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    op_d      = op_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_HOLD:  done_d = 1'b1;
            OP_LOAD:  begin y_d = bus.data;   done_d = 1'b1; end
            OP_CLEAR: begin y_d = '0;         done_d = 1'b1; end
            default: begin
              if (amt_n == '0) begin
                done_d = 1'b1;
              end else begin
                y_d       = shifted[WIDTH-1:0];
                ser_out_d = shifted[WIDTH];
                op_d      = bus.op;
                if (amt_n == AMT_ONE) begin
                  done_d = 1'b1;
                end else begin
                  state_d = SHIFT;
                  cnt_d   = amt_n - AMT_ONE;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        y_d       = shifted[WIDTH-1:0];
        ser_out_d = shifted[WIDTH];
        cnt_d     = cnt_q - AMT_ONE;
        if (cnt_q == AMT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= OP_HOLD;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.ser_out = ser_out_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
endmodule
